// File: rtl/swc_alloc_arb_pkg.sv
// Shared types for the swcore page allocator arbiter: op and FSM
// encodings, plus op priority and op-to-command helpers.
package swc_alloc_arb_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ALLOC,
        OP_FREE,
        OP_FORCE_FREE,
        OP_SET_USECNT
    } t_alloc_op;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } t_arb_state;

    // Command vector bit positions
    localparam int C_CMD_ALLOC  = 0;
    localparam int C_CMD_FREE   = 1;
    localparam int C_CMD_FFREE  = 2;
    localparam int C_CMD_SETCNT = 3;

    // Highest-priority op among one port's request bits.
    function automatic t_alloc_op f_op_prio(
        input logic alloc,
        input logic free,
        input logic force_free,
        input logic set_usecnt
    );
        if (force_free)
            return OP_FORCE_FREE;
        else if (free)
            return OP_FREE;
        else if (set_usecnt)
            return OP_SET_USECNT;
        else if (alloc)
            return OP_ALLOC;
        else
            return OP_NONE;
    endfunction

    // One-hot core command for an op.
    function automatic logic [3:0] f_op_cmd(input t_alloc_op op);
        logic [3:0] cmd;
        cmd = '0;
        unique case (op)
            OP_ALLOC:      cmd[C_CMD_ALLOC]  = 1'b1;
            OP_FREE:       cmd[C_CMD_FREE]   = 1'b1;
            OP_FORCE_FREE: cmd[C_CMD_FFREE]  = 1'b1;
            OP_SET_USECNT: cmd[C_CMD_SETCNT] = 1'b1;
            default:       cmd = '0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/swc_rr_picker.sv
// Round-robin picker: first pending bit at or after ptr_i (wrapping).
// Ports: pending_i, ptr_i in; grant_o (one-hot), idx_o, valid_o out.
module swc_rr_picker #(
    parameter int g_num   = 7,
    parameter int g_ptr_w = 3
) (
    input  logic [g_num-1:0]   pending_i,
    input  logic [g_ptr_w-1:0] ptr_i,
    output logic [g_num-1:0]   grant_o,
    output logic [g_ptr_w-1:0] idx_o,
    output logic               valid_o
);

    logic [g_ptr_w-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = ptr_i;
        for (int k = 0; k < g_num; k++) begin
            if (!valid_o && pending_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
            if (cand == g_ptr_w'(g_num - 1))
                cand = '0;
            else
                cand = cand + g_ptr_w'(1);
        end
    end

endmodule

// File: rtl/swc_page_alloc_arbiter.sv
// Round-robin arbiter sharing one swcore page allocator core among
// g_num_ports requesters (alloc/free/force_free/set_usecnt).
// Ports: rq_*_i per-port level requests, rq_done_o done pulse and
// rq_pgaddr_alloc_o page; core_*_o one-hot command to the core,
// core_*_i core status. Optional SWC_ALLOC_ARB_STATS_EN adds
// page usage counters on stat_pages_used_o / stat_pages_peak_o
// (tied to 0 when undefined).
module swc_page_alloc_arbiter
    import swc_alloc_arb_pkg::*;
#(
    parameter int g_num_ports       = 7,
    parameter int g_page_addr_width = 10,
    parameter int g_usecnt_width    = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic [g_num_ports-1:0]                     rq_alloc_i,
    input  logic [g_num_ports-1:0]                     rq_free_i,
    input  logic [g_num_ports-1:0]                     rq_force_free_i,
    input  logic [g_num_ports-1:0]                     rq_set_usecnt_i,
    input  logic [g_num_ports*g_page_addr_width-1:0]   rq_pgaddr_i,
    input  logic [g_num_ports*g_usecnt_width-1:0]      rq_usecnt_i,
    output logic [g_num_ports-1:0]                     rq_done_o,
    output logic [g_page_addr_width-1:0]               rq_pgaddr_alloc_o,
    output logic                                       core_alloc_o,
    output logic                                       core_free_o,
    output logic                                       core_force_free_o,
    output logic                                       core_set_usecnt_o,
    output logic [g_page_addr_width-1:0]               core_pgaddr_o,
    output logic [g_usecnt_width-1:0]                  core_usecnt_o,
    input  logic                                       core_done_i,
    input  logic [g_page_addr_width-1:0]               core_pgaddr_alloc_i,
    input  logic                                       core_free_last_usecnt_i,
    input  logic                                       core_nomem_i,
    output logic [g_page_addr_width:0]                 stat_pages_used_o,
    output logic [g_page_addr_width:0]                 stat_pages_peak_o
);

    localparam int N  = g_num_ports;
    localparam int W  = g_page_addr_width;
    localparam int U  = g_usecnt_width;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    t_arb_state      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [W-1:0]    pg_q, pg_d;
    logic [U-1:0]    cnt_q, cnt_d;
    logic [N-1:0]    done_q, done_d;
    logic [W-1:0]    pga_q, pga_d;

    logic [N-1:0]    pending;
    logic [N-1:0]    pick_oh;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;
    t_alloc_op       sel_op;
    logic            op_done;

    // Alloc is held off (not dropped) while the core is out of pages.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pending[i] = rq_force_free_i[i] | rq_free_i[i]
                       | rq_set_usecnt_i[i]
                       | (rq_alloc_i[i] & ~core_nomem_i);
        end
    end

    swc_rr_picker #(
        .g_num   (N),
        .g_ptr_w (PW)
    ) u_picker (
        .pending_i (pending),
        .ptr_i     (ptr_q),
        .grant_o   (pick_oh),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    assign op_done = (state_q == S_BUSY) && core_done_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        pg_d    = pg_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        pga_d   = pga_q;
        sel_op  = OP_NONE;
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    sel_op = f_op_prio(
                        rq_alloc_i[pick_idx] & ~core_nomem_i,
                        rq_free_i[pick_idx],
                        rq_force_free_i[pick_idx],
                        rq_set_usecnt_i[pick_idx]);
                    win_d = pick_idx;
                    if (pick_idx == PW'(N - 1))
                        ptr_d = '0;
                    else
                        ptr_d = pick_idx + PW'(1);
                    pg_d    = rq_pgaddr_i[int'(pick_idx)*W +: W];
                    cnt_d   = rq_usecnt_i[int'(pick_idx)*U +: U];
                    cmd_d   = f_op_cmd(sel_op);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (core_done_i) begin
                    cmd_d         = '0;
                    done_d[win_q] = 1'b1;
                    pga_d         = core_pgaddr_alloc_i;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                // Done pulse is visible this cycle; re-arbitrate only
                // after the requester had a chance to drop its level.
                pga_d   = '0;
                pg_d    = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cmd_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cmd_q   <= '0;
            pg_q    <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            pga_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            pg_q    <= pg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pga_q   <= pga_d;
        end
    end

    assign core_alloc_o      = cmd_q[C_CMD_ALLOC];
    assign core_free_o       = cmd_q[C_CMD_FREE];
    assign core_force_free_o = cmd_q[C_CMD_FFREE];
    assign core_set_usecnt_o = cmd_q[C_CMD_SETCNT];
    assign core_pgaddr_o     = pg_q;
    assign core_usecnt_o     = cnt_q;
    assign rq_done_o         = done_q;
    assign rq_pgaddr_alloc_o = pga_q;

`ifdef SWC_ALLOC_ARB_STATS_EN
    logic [W:0] used_q, used_d;
    logic [W:0] peak_q, peak_d;

    always_comb begin
        used_d = used_q;
        peak_d = peak_q;
        if (op_done) begin
            if (cmd_q[C_CMD_ALLOC]) begin
                if (used_q != '1)
                    used_d = used_q + 1'b1;
            end else if ((cmd_q[C_CMD_FREE] && core_free_last_usecnt_i)
                         || cmd_q[C_CMD_FFREE]) begin
                if (used_q != '0)
                    used_d = used_q - 1'b1;
            end
        end
        if (used_d > peak_q)
            peak_d = used_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            used_q <= '0;
            peak_q <= '0;
        end else begin
            used_q <= used_d;
            peak_q <= peak_d;
        end
    end

    assign stat_pages_used_o = used_q;
    assign stat_pages_peak_o = peak_q;
`else
    logic unused_stats;
    assign unused_stats      = core_free_last_usecnt_i | op_done;
    assign stat_pages_used_o = '0;
    assign stat_pages_peak_o = '0;
`endif

endmodule
